// File: rtl/cordic_pkg.sv
// Shared constants for the vectoring CORDIC pipeline: arctangent table,
// gain-compensation constant and angle helpers (binary-angle format).
package cordic_pkg;

  // atan(2^-k) for a 16-bit binary angle (value / 2^15 * pi)
  localparam int ATAN_TABLE [0:15] = '{
    8192, 4836, 2555, 1297, 651, 326, 163, 81,
    41,   20,   10,   5,    3,   1,   1,   0
  };

  // 1/1.64676 in Q1.15
  localparam int CORDIC_GAIN_Q15 = 19898;

  function automatic int ang_90(input int unsigned ang_w);
    return 1 << (ang_w - 2);
  endfunction

  function automatic int atan_val(input int unsigned k, input int unsigned ang_w);
    return ATAN_TABLE[k] >>> (16 - ang_w);
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered vectoring micro-rotation; DATA_W here is the internal
// (already guard-extended) datapath width. Valid and tag ride along.
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int unsigned SHIFT  = 0,
  parameter int unsigned DATA_W = 14,
  parameter int unsigned ANG_W  = 16,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] y_i,
  input  logic signed [ANG_W-1:0]  z_i,
  input  logic        [TAG_W-1:0]  tag_i,
  output logic                     valid_o,
  output logic signed [DATA_W-1:0] x_o,
  output logic signed [DATA_W-1:0] y_o,
  output logic signed [ANG_W-1:0]  z_o,
  output logic        [TAG_W-1:0]  tag_o
);

  localparam logic signed [ANG_W-1:0] ATAN = ANG_W'(atan_val(SHIFT, ANG_W));

  logic                     valid_q;
  logic signed [DATA_W-1:0] x_d, x_q, y_d, y_q;
  logic signed [ANG_W-1:0]  z_d, z_q;
  logic        [TAG_W-1:0]  tag_q;

  // Drive y toward zero; both shifts use the pre-update operands.
  always_comb begin
    x_d = x_i;
    y_d = y_i;
    z_d = z_i;
    if (!y_i[DATA_W-1]) begin
      x_d = x_i + (y_i >>> SHIFT);
      y_d = y_i - (x_i >>> SHIFT);
      z_d = z_i + ATAN;
    end else begin
      x_d = x_i - (y_i >>> SHIFT);
      y_d = y_i + (x_i >>> SHIFT);
      z_d = z_i - ATAN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_i;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      tag_q   <= tag_i;
    end
  end

  assign valid_o = valid_q;
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign z_o     = z_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/cordic_vectoring_pipe.sv
// Fully pipelined four-quadrant vectoring CORDIC: magnitude and atan2 after
// ITER+2 cycles. Define CORDIC_GAIN_COMP_EN to scale mag_o by 1/gain.
module cordic_vectoring_pipe
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ITER   = 8,
  parameter int unsigned ANG_W  = 16,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] y_i,
  input  logic        [TAG_W-1:0]  tag_i,
  output logic                     valid_o,
  output logic        [DATA_W+1:0] mag_o,
  output logic signed [ANG_W-1:0]  ang_o,
  output logic        [TAG_W-1:0]  tag_o
);

  localparam int unsigned XW = DATA_W + 2;
  localparam logic signed [ANG_W-1:0] ANG90 = ANG_W'(ang_90(ANG_W));

  logic signed [XW-1:0]    xe, ye;
  logic signed [XW-1:0]    x0_d, x0_q, y0_d, y0_q;
  logic signed [ANG_W-1:0] z0_d, z0_q;
  logic                    v0_q;
  logic        [TAG_W-1:0] t0_q;

  logic                    vs [0:ITER];
  logic signed [XW-1:0]    xs [0:ITER];
  logic signed [XW-1:0]    ys [0:ITER];
  logic signed [ANG_W-1:0] zs [0:ITER];
  logic        [TAG_W-1:0] ts [0:ITER];

  logic                    valid_q;
  logic        [XW-1:0]    mag_d, mag_q;
  logic signed [ANG_W-1:0] ang_q;
  logic        [TAG_W-1:0] tag_q;

  assign xe = XW'(x_i);
  assign ye = XW'(y_i);

  // Fold the left half-plane into x >= 0 with a +/-90 degree rotation.
  always_comb begin
    x0_d = xe;
    y0_d = ye;
    z0_d = '0;
    if (xe[XW-1]) begin
      if (!ye[XW-1]) begin
        x0_d = ye;
        y0_d = -xe;
        z0_d = ANG90;
      end else begin
        x0_d = -ye;
        y0_d = xe;
        z0_d = -ANG90;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v0_q <= 1'b0;
      x0_q <= '0;
      y0_q <= '0;
      z0_q <= '0;
      t0_q <= '0;
    end else begin
      v0_q <= valid_i;
      x0_q <= x0_d;
      y0_q <= y0_d;
      z0_q <= z0_d;
      t0_q <= tag_i;
    end
  end

  assign vs[0] = v0_q;
  assign xs[0] = x0_q;
  assign ys[0] = y0_q;
  assign zs[0] = z0_q;
  assign ts[0] = t0_q;

  for (genvar k = 0; k < ITER; k++) begin : g_stage
    cordic_vec_stage #(
      .SHIFT (k),
      .DATA_W(XW),
      .ANG_W (ANG_W),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk    (clk),
      .rstn   (rstn),
      .valid_i(vs[k]),
      .x_i    (xs[k]),
      .y_i    (ys[k]),
      .z_i    (zs[k]),
      .tag_i  (ts[k]),
      .valid_o(vs[k+1]),
      .x_o    (xs[k+1]),
      .y_o    (ys[k+1]),
      .z_o    (zs[k+1]),
      .tag_o  (ts[k+1])
    );
  end

  // Residual y is not needed once the vector sits on the x axis.
  logic unused_y_final;
  assign unused_y_final = ^ys[ITER];

`ifdef CORDIC_GAIN_COMP_EN
  logic signed [XW+16:0] prod;
  always_comb begin
    prod  = (XW+17)'(xs[ITER]) * (XW+17)'(CORDIC_GAIN_Q15);
    mag_d = XW'(prod >>> 15);
  end
`else
  always_comb begin
    mag_d = xs[ITER];
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      mag_q   <= '0;
      ang_q   <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= vs[ITER];
      mag_q   <= mag_d;
      ang_q   <= zs[ITER];
      tag_q   <= ts[ITER];
    end
  end

  assign valid_o = valid_q;
  assign mag_o   = mag_q;
  assign ang_o   = ang_q;
  assign tag_o   = tag_q;

endmodule

// File: tb/tb_cordic_vectoring_pipe.sv
// Scoreboard bench for cordic_vectoring_pipe: real-valued sqrt/atan2 model,
// queue of expected results, negedge monitor checking every cycle.
module tb_cordic_vectoring_pipe;

  localparam int DATA_W = 12;
  localparam int ITER   = 8;
  localparam int ANG_W  = 16;
  localparam int TAG_W  = 4;
  localparam int LAT    = ITER + 2;
  localparam real PI    = 3.14159265358979;
  localparam real ATOL  = 100.0;
`ifdef CORDIC_GAIN_COMP_EN
  localparam real GAIN  = 1.0;
  localparam real MTOL  = 3.0;
  localparam real MTOLR = 4.0;
`else
  localparam real GAIN  = 1.646760258;
  localparam real MTOL  = 5.0;
  localparam real MTOLR = 6.0;
`endif

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic                     valid_i = 1'b0;
  logic signed [DATA_W-1:0] x_i = '0;
  logic signed [DATA_W-1:0] y_i = '0;
  logic        [TAG_W-1:0]  tag_i = '0;
  logic                     valid_o;
  logic        [DATA_W+1:0] mag_o;
  logic signed [ANG_W-1:0]  ang_o;
  logic        [TAG_W-1:0]  tag_o;

  cordic_vectoring_pipe #(
    .DATA_W(DATA_W),
    .ITER  (ITER),
    .ANG_W (ANG_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .valid_i(valid_i),
    .x_i    (x_i),
    .y_i    (y_i),
    .tag_i  (tag_i),
    .valid_o(valid_o),
    .mag_o  (mag_o),
    .ang_o  (ang_o),
    .tag_o  (tag_o)
  );

  typedef struct {
    int  due;
    real mag;
    real ang;
    int  tag;
    real mtol;
  } exp_t;

  exp_t sbq[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_near(input string name, input real act, input real exp,
                            input real tol, input bit wrap);
    real d;
    d = act - exp;
    if (wrap) begin
      while (d > 32768.0) d -= 65536.0;
      while (d < -32768.0) d += 65536.0;
    end
    total++;
    if (d > tol || d < -tol) begin
      bad++;
      $display("FAIL %s: got %0.1f, expected %0.1f +/- %0.1f (cycle %0d)",
               name, act, exp, tol, cyc);
    end
  endtask

  function automatic exp_t model(input int x, input int y, input int tag,
                                 input int due, input real mtol);
    exp_t e;
    real  rx, ry;
    rx     = real'(x);
    ry     = real'(y);
    e.due  = due;
    e.mag  = GAIN * $sqrt(rx * rx + ry * ry);
    e.ang  = $atan2(ry, rx) / PI * 32768.0;
    e.tag  = tag;
    e.mtol = mtol;
    return e;
  endfunction

  task automatic drive(input bit v, input int x, input int y, input int tag, input real mtol);
    @(posedge clk);
    #1;
    valid_i = v;
    x_i     = DATA_W'(x);
    y_i     = DATA_W'(y);
    tag_i   = TAG_W'(tag);
    if (v) sbq.push_back(model(x, y, tag, cyc + LAT, mtol));
  endtask

  task automatic drive_rand(input int tag);
    int x, y;
    do begin
      x = int'($urandom_range(0, 4095)) - 2048;
      y = int'($urandom_range(0, 4095)) - 2048;
    end while (x * x + y * y < 1500 * 1500);
    drive(1'b1, x, y, tag, MTOLR);
  endtask

  // Monitor: every cycle out of reset, valid_o must match the scoreboard head.
  exp_t mon_e;
  bit   mon_v;
  always @(negedge clk) begin
    if (rstn) begin
      mon_v = (sbq.size() > 0) && (sbq[0].due == cyc);
      check_eq("valid_o", int'(valid_o), int'(mon_v));
      if (mon_v) begin
        mon_e = sbq.pop_front();
        if (valid_o) begin
          check_eq("tag_o", int'(tag_o), mon_e.tag);
          check_near("mag_o", real'(mag_o), mon_e.mag, mon_e.mtol, 1'b0);
          check_near("ang_o", real'(ang_o), mon_e.ang, ATOL, 1'b1);
        end
      end
    end
  end

  initial begin
    // Reset state
    @(posedge clk);
    #2;
    check_eq("rst valid_o", int'(valid_o), 0);
    check_eq("rst mag_o", int'(mag_o), 0);
    check_eq("rst ang_o", int'(ang_o), 0);
    check_eq("rst tag_o", int'(tag_o), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Axis, quadrant and extreme vectors, spaced with bubbles
    drive(1'b1, 100, 0, 1, MTOL);
    drive(1'b0, 0, 0, 0, MTOL);
    drive(1'b1, 0, 100, 2, MTOL);
    drive(1'b1, -100, 0, 3, MTOL);
    drive(1'b0, 0, 0, 0, MTOL);
    drive(1'b1, -100, -100, 4, MTOL);
    drive(1'b1, -2048, -2048, 5, MTOL);
    drive(1'b1, 2047, -2048, 6, MTOL);
    drive(1'b1, -2048, 2047, 7, MTOL);
    drive(1'b0, 0, 0, 0, MTOL);
    repeat (LAT + 2) drive(1'b0, 0, 0, 0, MTOL);

    // 20 back-to-back, then a bubble, then a sparser random stream
    for (int i = 0; i < 20; i++) drive_rand(i % 16);
    drive(1'b0, 0, 0, 0, MTOL);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, 0, 0, 0, MTOL);
      else drive_rand(int'($urandom_range(0, 15)));
    end

    // Mid-stream reset with the pipeline full of valid samples
    for (int i = 0; i < 14; i++) drive_rand(i % 16);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    rstn    = 1'b0;
    sbq.delete();
    #1;
    check_eq("midrst valid_o", int'(valid_o), 0);
    check_eq("midrst mag_o", int'(mag_o), 0);
    check_eq("midrst ang_o", int'(ang_o), 0);
    check_eq("midrst tag_o", int'(tag_o), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) drive(1'b0, 0, 0, 0, MTOL);
    drive(1'b1, -100, -100, 9, MTOL);
    drive(1'b0, 0, 0, 0, MTOL);

    // Drain: everything expected must have appeared within its budget
    repeat (LAT + 3) @(posedge clk);
    check_eq("drain pending", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
